// File: rtl/mul_pkg.sv
`default_nettype none
// ============================================================================
// mul_pkg : shared types and constants for the radix-4 Booth multiply unit
// Revision: 1.0
// ============================================================================
package mul_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int NUM_DIGITS = 16;
    localparam int PP_W       = 34;
    localparam int ACC_W      = 64;

    // Recode triple {b[2j+1], b[2j], b[2j-1]}
    localparam logic [2:0] BOOTH_Z0  = 3'b000;
    localparam logic [2:0] BOOTH_P1A = 3'b001;
    localparam logic [2:0] BOOTH_P1B = 3'b010;
    localparam logic [2:0] BOOTH_P2  = 3'b011;
    localparam logic [2:0] BOOTH_M2  = 3'b100;
    localparam logic [2:0] BOOTH_M1A = 3'b101;
    localparam logic [2:0] BOOTH_M1B = 3'b110;
    localparam logic [2:0] BOOTH_Z1  = 3'b111;

endpackage
`default_nettype wire

// File: rtl/booth_pp_gen.sv
`default_nettype none
// ============================================================================
// booth_pp_gen : combinational radix-4 Booth partial-product selector
// Revision: 1.0
// ============================================================================
module booth_pp_gen
    import mul_pkg::*;
(
    input  logic [31:0]     a,
    input  logic [2:0]      triple,
    output logic [PP_W-1:0] pp
);

    // Two guard bits keep -a and -2a exact even for a = -2^31
    logic [PP_W-1:0] a_ext;
    assign a_ext = {{(PP_W-32){a[31]}}, a};

    always_comb begin
        pp = '0;
        case (triple)
            BOOTH_Z0, BOOTH_Z1:   pp = '0;
            BOOTH_P1A, BOOTH_P1B: pp = a_ext;
            BOOTH_P2:             pp = a_ext << 1;
            BOOTH_M2:             pp = -(a_ext << 1);
            BOOTH_M1A, BOOTH_M1B: pp = -a_ext;
            default:              pp = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mul_sequencer.sv
`default_nettype none
// ============================================================================
// mul_sequencer : multi-cycle 32x32 signed radix-4 Booth multiplier
// Revision: 1.0
// ============================================================================
module mul_sequencer
    import mul_pkg::*;
#(
    parameter int DIGITS_PER_CYCLE = 1   // 1, 2, 4 or 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int         KW     = 5;
    localparam logic [KW-1:0] K_STEP = KW'(DIGITS_PER_CYCLE);
    localparam logic [KW-1:0] K_END  = KW'(NUM_DIGITS);

    state_t            state;
    state_t            state_next;
    logic [31:0]       a_r;
    logic [31:0]       b_r;
    logic [ACC_W-1:0]  acc;
    logic [KW-1:0]     k;
    logic [KW-1:0]     k_next;
    logic [32:0]       b_ext;
    logic [ACC_W-1:0]  step_sum;
    logic [ACC_W-1:0]  acc_sum;
    logic [ACC_W-1:0]  pp_shifted [DIGITS_PER_CYCLE];

    // Implicit b[-1] = 0 sits at bit 0, so digit j's triple starts at bit 2j
    assign b_ext  = {b_r, 1'b0};
    assign k_next = k + K_STEP;

    generate
        for (genvar g = 0; g < DIGITS_PER_CYCLE; g++) begin : g_digit
            logic [5:0]      digit_pos;
            logic [2:0]      triple;
            logic [PP_W-1:0] pp;

            assign digit_pos = {k, 1'b0} + 6'(2 * g);
            assign triple    = 3'(b_ext >> digit_pos);

            booth_pp_gen u_pp (
                .a      (a_r),
                .triple (triple),
                .pp     (pp)
            );

            assign pp_shifted[g] = {{(ACC_W-PP_W){pp[PP_W-1]}}, pp} << digit_pos;
        end
    endgenerate

    always_comb begin
        step_sum = '0;
        for (int i = 0; i < DIGITS_PER_CYCLE; i++) begin
            step_sum = step_sum + pp_shifted[i];
        end
    end

    assign acc_sum = acc + step_sum;

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (k_next >= K_END) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            a_r   <= '0;
            b_r   <= '0;
            acc   <= '0;
            k     <= '0;
            hi    <= '0;
            lo    <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_r <= op_a;
                        b_r <= op_b;
                        acc <= '0;
                        k   <= '0;
                    end
                end
                RUN: begin
                    acc <= acc_sum;
                    k   <= k_next;
                    if (state_next == DONE) begin
                        hi <= acc_sum[63:32];
                        lo <= acc_sum[31:0];
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

endmodule
`default_nettype wire
